// File: rtl/gb_pkg.sv
// Shared Game Boy types and constants for the OAM responder and its DMA engine.
package gb_pkg;

  typedef enum logic [1:0] {
    HBlank  = 2'd0,
    VBlank  = 2'd1,
    OAMScan = 2'd2,
    Draw    = 2'd3
  } PPUState;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } DmaState;

  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam int          OAM_SIZE       = 160;
  localparam logic [15:0] DMA_REG        = 16'hFF46;
  localparam int          TICKS_PER_BYTE = 4;
  localparam int          TICK_W         = (TICKS_PER_BYTE > 1) ? $clog2(TICKS_PER_BYTE) : 1;
  localparam logic [15:0] OAM_END        = OAM_BASE + 16'(OAM_SIZE);
  localparam logic [15:0] UNUSED_END     = 16'hFEFF;

  function automatic logic in_oam(input logic [15:0] addr);
    return (addr >= OAM_BASE) && (addr < OAM_END);
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// FF46 OAM-DMA copy engine: start/transfer FSM, byte and tick counters,
// source read handshake, and the OAM write port it drives.
module oam_dma_engine
  import gb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic        start_in,
  input  logic [7:0]  start_page_in,
  input  logic [7:0]  dma_data_in,
  input  logic        dma_data_valid_in,
  output logic [15:0] dma_addr_out,
  output logic        dma_rd_out,
  output logic        dma_active_out,
  output logic        oam_wr_en_out,
  output logic [7:0]  oam_wr_idx_out,
  output logic [7:0]  oam_wr_data_out
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BYTE - 1);
  localparam logic [7:0]        LAST_IDX  = 8'(OAM_SIZE - 1);

  DmaState           state_q, state_d;
  logic [7:0]        src_q, src_d;
  logic [7:0]        idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_en;

  // A new FF46 write always wins: it drops any outstanding source read, so a
  // late valid for the old page finds rd_pend_q low and is ignored.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    rd_pend_d = rd_pend_q;
    wr_en     = 1'b0;
    if (start_in) begin
      state_d   = START;
      src_d     = start_page_in;
      idx_d     = 8'h00;
      tick_d    = '0;
      rd_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        START: if (tclk_in) state_d = XFER;
        XFER: begin
          if (tclk_in) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            if (tick_q == TICK_LAST && !rd_pend_q) rd_pend_d = 1'b1;
          end
          if (rd_pend_q && dma_data_valid_in) begin
            wr_en     = 1'b1;
            rd_pend_d = 1'b0;
            idx_d     = idx_q + 8'd1;
            if (idx_q == LAST_IDX) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      src_q     <= 8'h00;
      idx_q     <= 8'h00;
      tick_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign dma_addr_out    = {src_q, idx_q};
  assign dma_rd_out      = rd_pend_q;
  assign dma_active_out  = (state_q == XFER);
  assign oam_wr_en_out   = wr_en;
  assign oam_wr_idx_out  = idx_q;
  assign oam_wr_data_out = dma_data_in;

endmodule

// File: rtl/oam_responder.sv
// OAM memory responder: 160-byte array, PPU and CPU read/write ports with
// PPU-mode and DMA access blocking, and the FF46 DMA register.
module oam_responder
  import gb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [1:0]  ppu_mode_in,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_valid_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_rd_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_valid_out,
  output logic [15:0] dma_addr_out,
  output logic        dma_rd_out,
  input  logic [7:0]  dma_data_in,
  input  logic        dma_data_valid_in,
  output logic        dma_active_out
);

  logic [7:0] oam_mem [OAM_SIZE];

  logic [7:0] ppu_data_q, ppu_data_d, cpu_data_q, cpu_data_d, dma_reg_q, dma_reg_d;
  logic       ppu_valid_q, ppu_valid_d, cpu_valid_q, cpu_valid_d;
  logic       dma_wr_en, dma_start, cpu_oam_wr, cpu_blocked;
  logic       ppu_in_oam, cpu_in_oam, cpu_in_unused;
  logic [7:0] dma_wr_idx, dma_wr_data, ppu_idx, cpu_idx;
  PPUState    ppu_mode;

  oam_dma_engine u_dma (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .tclk_in           (tclk_in),
    .start_in          (dma_start),
    .start_page_in     (cpu_data_in),
    .dma_data_in       (dma_data_in),
    .dma_data_valid_in (dma_data_valid_in),
    .dma_addr_out      (dma_addr_out),
    .dma_rd_out        (dma_rd_out),
    .dma_active_out    (dma_active_out),
    .oam_wr_en_out     (dma_wr_en),
    .oam_wr_idx_out    (dma_wr_idx),
    .oam_wr_data_out   (dma_wr_data)
  );

  // OAM_BASE is page aligned, so the index is simply the low address byte.
  always_comb begin
    ppu_mode      = PPUState'(ppu_mode_in);
    ppu_in_oam    = in_oam(ppu_addr_in);
    cpu_in_oam    = in_oam(cpu_addr_in);
    cpu_in_unused = (cpu_addr_in >= OAM_END) && (cpu_addr_in <= UNUSED_END);
    ppu_idx       = ppu_addr_in[7:0] - OAM_BASE[7:0];
    cpu_idx       = cpu_addr_in[7:0] - OAM_BASE[7:0];
    cpu_blocked   = (ppu_mode == OAMScan) || (ppu_mode == Draw) || dma_active_out;
    dma_start     = cpu_wr_in && (cpu_addr_in == DMA_REG);
    cpu_oam_wr    = cpu_wr_in && cpu_in_oam && !cpu_blocked;
    dma_reg_d     = dma_start ? cpu_data_in : dma_reg_q;

    ppu_valid_d = ppu_valid_in;
    ppu_data_d  = 8'h00;
    if (ppu_valid_in) begin
      ppu_data_d = (ppu_in_oam && !dma_active_out) ? oam_mem[ppu_idx] : 8'hFF;
    end

    cpu_valid_d = 1'b0;
    cpu_data_d  = 8'h00;
    if (cpu_rd_in && !cpu_wr_in) begin
      if (cpu_in_oam) begin
        cpu_valid_d = 1'b1;
        cpu_data_d  = cpu_blocked ? 8'hFF : oam_mem[cpu_idx];
      end else if (cpu_in_unused) begin
        cpu_valid_d = 1'b1;
      end else if (cpu_addr_in == DMA_REG) begin
        cpu_valid_d = 1'b1;
        cpu_data_d  = dma_reg_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ppu_data_q  <= 8'h00;
      ppu_valid_q <= 1'b0;
      cpu_data_q  <= 8'h00;
      cpu_valid_q <= 1'b0;
      dma_reg_q   <= 8'h00;
    end else begin
      ppu_data_q  <= ppu_data_d;
      ppu_valid_q <= ppu_valid_d;
      cpu_data_q  <= cpu_data_d;
      cpu_valid_q <= cpu_valid_d;
      dma_reg_q   <= dma_reg_d;
    end
  end

  // Single write port; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (dma_wr_en) begin
      oam_mem[dma_wr_idx] <= dma_wr_data;
    end else if (cpu_oam_wr) begin
      oam_mem[cpu_idx] <= cpu_data_in;
    end
  end

  assign ppu_data_out       = ppu_data_q;
  assign ppu_data_valid_out = ppu_valid_q;
  assign cpu_data_out       = cpu_data_q;
  assign cpu_data_valid_out = cpu_valid_q;

endmodule

// File: tb/tb_oam_responder.sv
// Scoreboard bench for oam_responder: directed CPU/PPU accesses and DMA runs
// against a page-dependent source memory model.
module tb_oam_responder;
  import gb_pkg::*;

  localparam int K_CPU_WR        = 0;
  localparam int K_CPU_RD        = 1;
  localparam int K_PPU_RD        = 2;
  localparam int K_CPU_RD_NONE   = 3;
  localparam int K_CPU_RDWR      = 4;
  localparam int K_PPU_RD_CPU_WR = 5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        tclk_in = 1'b1;
  logic [1:0]  ppu_mode_in = 2'd0;
  logic [15:0] ppu_addr_in = 16'h0000;
  logic        ppu_valid_in = 1'b0;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_valid_out;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic        cpu_rd_in = 1'b0;
  logic        cpu_wr_in = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_valid_out;
  logic [15:0] dma_addr_out;
  logic        dma_rd_out;
  logic [7:0]  dma_data_in = 8'h00;
  logic        dma_data_valid_in = 1'b0;
  logic        dma_active_out;

  always #5 clk_in = ~clk_in;

  oam_responder dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .tclk_in            (tclk_in),
    .ppu_mode_in        (ppu_mode_in),
    .ppu_addr_in        (ppu_addr_in),
    .ppu_valid_in       (ppu_valid_in),
    .ppu_data_out       (ppu_data_out),
    .ppu_data_valid_out (ppu_data_valid_out),
    .cpu_addr_in        (cpu_addr_in),
    .cpu_rd_in          (cpu_rd_in),
    .cpu_wr_in          (cpu_wr_in),
    .cpu_data_in        (cpu_data_in),
    .cpu_data_out       (cpu_data_out),
    .cpu_data_valid_out (cpu_data_valid_out),
    .dma_addr_out       (dma_addr_out),
    .dma_rd_out         (dma_rd_out),
    .dma_data_in        (dma_data_in),
    .dma_data_valid_in  (dma_data_valid_in),
    .dma_active_out     (dma_active_out)
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        ppu_q[$];
  exp_t        cpu_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] exp_dma_addr = 16'h0000;
  int          src_req_count = 0;
  int          start_cyc = 0;
  int          last_req_cyc = 0;
  bit          first_req = 1'b0;

  // Cycle counter used for latency and DMA pacing checks.
  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Source memory: low address byte ^ 5A, offset by the page distance from C1.
  function automatic logic [7:0] src_model(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
  endfunction

  // One access per call; reads push the expected byte due one cycle after sampling.
  task automatic applyStimulus(input int kind, input logic [15:0] addr,
                               input logic [7:0] data, input logic [7:0] expv);
    exp_t e;
    @(posedge clk_in); #1;
    e.data = expv;
    e.due  = cyc + 1;
    case (kind)
      K_CPU_WR: begin
        cpu_addr_in = addr; cpu_data_in = data; cpu_wr_in = 1'b1;
      end
      K_CPU_RD: begin
        cpu_addr_in = addr; cpu_rd_in = 1'b1; cpu_q.push_back(e);
      end
      K_PPU_RD: begin
        ppu_addr_in = addr; ppu_valid_in = 1'b1; ppu_q.push_back(e);
      end
      K_CPU_RD_NONE: begin
        cpu_addr_in = addr; cpu_rd_in = 1'b1;
      end
      K_CPU_RDWR: begin
        cpu_addr_in = addr; cpu_data_in = data; cpu_rd_in = 1'b1; cpu_wr_in = 1'b1;
      end
      K_PPU_RD_CPU_WR: begin
        cpu_addr_in = addr; cpu_data_in = data; cpu_wr_in = 1'b1;
        ppu_addr_in = addr; ppu_valid_in = 1'b1; ppu_q.push_back(e);
      end
      default: ;
    endcase
    @(posedge clk_in); #1;
    cpu_rd_in    = 1'b0;
    cpu_wr_in    = 1'b0;
    ppu_valid_in = 1'b0;
    if (kind == K_CPU_RD_NONE || kind == K_CPU_RDWR)
      checkOutput("cpu_no_response", {31'd0, cpu_data_valid_out}, 32'd0);
    if (kind == K_CPU_WR && addr == DMA_REG) begin
      exp_dma_addr  = {data, 8'h00};
      start_cyc     = cyc - 1;
      first_req     = 1'b1;
      src_req_count = 0;
    end
  endtask

  // Start a DMA: one cycle in START with active low, then active high.
  task automatic startDma(input logic [7:0] page);
    applyStimulus(K_CPU_WR, DMA_REG, page, 8'h00);
    checkOutput("dma_active_in_start", {31'd0, dma_active_out}, 32'd0);
    @(posedge clk_in); #1;
    checkOutput("dma_active_in_xfer", {31'd0, dma_active_out}, 32'd1);
  endtask

  task automatic waitRequests(input int n);
    for (int i = 0; i < 1000 && src_req_count < n; i++) begin
      @(posedge clk_in); #1;
    end
    checkOutput("dma_requests_reached", {31'd0, src_req_count >= n}, 32'd1);
  endtask

  task automatic waitDmaDone();
    for (int i = 0; i < 2000 && dma_active_out; i++) begin
      @(posedge clk_in); #1;
    end
    checkOutput("dma_done", {31'd0, dma_active_out}, 32'd0);
  endtask

  task automatic pulseClocks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  // Scoreboard monitor: every valid pops one expectation and checks data and timing.
  initial forever begin
    exp_t e;
    @(negedge clk_in);
    if (ppu_data_valid_out) begin
      if (ppu_q.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL ppu_unexpected_valid: got data %0h, expected no response", ppu_data_out);
      end else begin
        e = ppu_q.pop_front();
        checkOutput("ppu_data", {24'd0, ppu_data_out}, {24'd0, e.data});
        checkOutput("ppu_latency", cyc, e.due);
      end
    end
    if (cpu_data_valid_out) begin
      if (cpu_q.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL cpu_unexpected_valid: got data %0h, expected no response", cpu_data_out);
      end else begin
        e = cpu_q.pop_front();
        checkOutput("cpu_data", {24'd0, cpu_data_out}, {24'd0, e.data});
        checkOutput("cpu_latency", cyc, e.due);
      end
    end
  end

  // DMA source: answers each new request at the next edge and checks address/pacing.
  initial forever begin
    @(negedge clk_in);
    if (dma_rd_out && !dma_data_valid_in) begin
      checkOutput("dma_addr", {16'd0, dma_addr_out}, {16'd0, exp_dma_addr});
      if (first_req) begin
        checkOutput("dma_first_latency", cyc - start_cyc, 32'd6);
        first_req = 1'b0;
      end else begin
        checkOutput("dma_byte_interval", cyc - last_req_cyc, 32'd4);
      end
      exp_dma_addr      = exp_dma_addr + 16'd1;
      last_req_cyc      = cyc;
      src_req_count++;
      dma_data_in       = src_model(dma_addr_out);
      dma_data_valid_in = 1'b1;
    end else begin
      dma_data_valid_in = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    pulseClocks(3);
    rst_in = 1'b0;
    checkOutput("rst_ppu_valid", {31'd0, ppu_data_valid_out}, 32'd0);
    checkOutput("rst_ppu_data", {24'd0, ppu_data_out}, 32'd0);
    checkOutput("rst_cpu_valid", {31'd0, cpu_data_valid_out}, 32'd0);
    checkOutput("rst_cpu_data", {24'd0, cpu_data_out}, 32'd0);
    checkOutput("rst_dma_addr", {16'd0, dma_addr_out}, 32'd0);
    checkOutput("rst_dma_rd", {31'd0, dma_rd_out}, 32'd0);
    checkOutput("rst_dma_active", {31'd0, dma_active_out}, 32'd0);
    applyStimulus(K_CPU_RD, DMA_REG, 8'h00, 8'h00);

    // HBlank write then read back on both ports.
    ppu_mode_in = 2'd0;
    applyStimulus(K_CPU_WR, 16'hFE05, 8'h3C, 8'h00);
    applyStimulus(K_PPU_RD, 16'hFE05, 8'h00, 8'h3C);
    applyStimulus(K_CPU_RD, 16'hFE05, 8'h00, 8'h3C);

    // OAMScan/Draw block CPU access; PPU still sees the stored byte.
    ppu_mode_in = 2'd2;
    applyStimulus(K_CPU_WR, 16'hFE05, 8'h77, 8'h00);
    applyStimulus(K_CPU_RD, 16'hFE05, 8'h00, 8'hFF);
    applyStimulus(K_PPU_RD, 16'hFE05, 8'h00, 8'h3C);
    ppu_mode_in = 2'd3;
    applyStimulus(K_CPU_RD, 16'hFE05, 8'h00, 8'hFF);
    ppu_mode_in = 2'd1;
    applyStimulus(K_CPU_RD, 16'hFE05, 8'h00, 8'h3C);
    ppu_mode_in = 2'd0;
    applyStimulus(K_CPU_RD, 16'hFE05, 8'h00, 8'h3C);

    // Unused region, unmapped address, read+write collision, read-before-write.
    applyStimulus(K_CPU_RD, 16'hFEA0, 8'h00, 8'h00);
    applyStimulus(K_CPU_RD, 16'hFEFF, 8'h00, 8'h00);
    applyStimulus(K_PPU_RD, 16'hFEA0, 8'h00, 8'hFF);
    applyStimulus(K_PPU_RD, 16'hFDFF, 8'h00, 8'hFF);
    applyStimulus(K_CPU_RD_NONE, 16'h8000, 8'h00, 8'h00);
    applyStimulus(K_CPU_RDWR, 16'hFE06, 8'h99, 8'h00);
    applyStimulus(K_CPU_RD, 16'hFE06, 8'h00, 8'h99);
    applyStimulus(K_CPU_WR, 16'hFE9F, 8'h11, 8'h00);
    applyStimulus(K_PPU_RD_CPU_WR, 16'hFE9F, 8'hAB, 8'h11);
    applyStimulus(K_PPU_RD, 16'hFE9F, 8'h00, 8'hAB);

    // Full DMA from page C1 with blocked accesses in the middle.
    startDma(8'hC1);
    pulseClocks(100);
    applyStimulus(K_CPU_WR, 16'hFE10, 8'hEE, 8'h00);
    applyStimulus(K_PPU_RD, 16'hFE00, 8'h00, 8'hFF);
    applyStimulus(K_CPU_RD, 16'hFE00, 8'h00, 8'hFF);
    waitDmaDone();
    checkOutput("dma_c1_byte_count", src_req_count, 32'd160);
    applyStimulus(K_CPU_RD, DMA_REG, 8'h00, 8'hC1);
    for (int i = 0; i < OAM_SIZE; i++)
      applyStimulus(K_PPU_RD, OAM_BASE + 16'(i), 8'h00, src_model({8'hC1, 8'(i)}));

    // Restart at byte 50: page C3 abandoned, page C2 copied in full.
    startDma(8'hC3);
    waitRequests(50);
    applyStimulus(K_CPU_WR, DMA_REG, 8'hC2, 8'h00);
    @(posedge clk_in); #1;
    checkOutput("dma_restart_active", {31'd0, dma_active_out}, 32'd1);
    waitDmaDone();
    checkOutput("dma_c2_byte_count", src_req_count, 32'd160);
    for (int i = 0; i < OAM_SIZE; i++)
      applyStimulus(K_PPU_RD, OAM_BASE + 16'(i), 8'h00, src_model({8'hC2, 8'(i)}));

    // Reset in the middle of a DMA: abort at once, keep bytes already written.
    startDma(8'hC1);
    waitRequests(4);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("midrst_dma_active", {31'd0, dma_active_out}, 32'd0);
    checkOutput("midrst_dma_rd", {31'd0, dma_rd_out}, 32'd0);
    rst_in = 1'b0;
    src_req_count = 0;
    pulseClocks(20);
    checkOutput("midrst_fsm_idle", src_req_count, 32'd0);
    checkOutput("midrst_active_stays_low", {31'd0, dma_active_out}, 32'd0);
    applyStimulus(K_CPU_RD, DMA_REG, 8'h00, 8'h00);
    applyStimulus(K_PPU_RD, 16'hFE00, 8'h00, src_model(16'hC100));
    applyStimulus(K_PPU_RD, 16'hFE02, 8'h00, src_model(16'hC102));
    applyStimulus(K_PPU_RD, 16'hFE64, 8'h00, src_model(16'hC264));

    pulseClocks(3);
    checkOutput("ppu_queue_drained", ppu_q.size(), 32'd0);
    checkOutput("cpu_queue_drained", cpu_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_responder.md
Name: oam_responder

Overview:
- Memory-side responder for Object Attribute Memory (OAM, FE00-FE9F, 160 bytes).
- Answers the PPU's OAM-scan read requests. The scan issues addr/valid and expects data with a valid strobe.
- Also serves CPU reads and writes, and runs the FF46 OAM-DMA copy engine.
- Applies Game Boy access blocking based on PPU mode and DMA activity.

Parameters:
- OAM_BASE, 16'hFE00, first OAM address.
- OAM_SIZE, 160, OAM bytes (40 sprites x 4).
- DMA_REG, 16'hFF46, DMA trigger register address.
- TICKS_PER_BYTE, 4, T-cycles per DMA byte (one M-cycle).

Ports:
- clk_in  input  1  system clock; reset is synchronous, active-high, sampled on clk_in.
- rst_in  input  1  synchronous active-high reset.
- tclk_in  input  1  T-cycle enable pulse (one clk_in wide).
- ppu_mode_in  input  2  PPU state: 0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw.
- ppu_addr_in  input  16  PPU read address.
- ppu_valid_in  input  1  PPU read request.
- ppu_data_out  output  8  PPU read data.
- ppu_data_valid_out  output  1  PPU read data valid.
- cpu_addr_in  input  16  CPU address.
- cpu_rd_in  input  1  CPU read strobe.
- cpu_wr_in  input  1  CPU write strobe.
- cpu_data_in  input  8  CPU write data.
- cpu_data_out  output  8  CPU read data.
- cpu_data_valid_out  output  1  CPU read data valid.
- dma_addr_out  output  16  DMA source address.
- dma_rd_out  output  1  DMA source read request.
- dma_data_in  input  8  DMA source data.
- dma_data_valid_in  input  1  DMA source data valid.
- dma_active_out  output  1  DMA in progress.

Behaviour:
- Reset values:
  - All outputs 0; DMA FSM in IDLE; byte counter 0; tick counter 0.
  - DMA register reads back 8'h00.
  - OAM array contents are not reset.
- PPU reads:
  - ppu_valid_in at clk edge N gives ppu_data_out and ppu_data_valid_out=1 at edge N+1, for exactly one clk.
  - In-range address (FE00-FE9F): returns the byte at index addr-OAM_BASE.
  - Out-of-range address: returns 8'hFF.
  - While dma_active_out=1: returns 8'hFF.
  - Same-cycle read and write to the same byte returns the old value (read-before-write).
- CPU reads (same 1-clk latency and valid rule as PPU):
  - FE00-FE9F: returns 8'hFF if ppu_mode_in is 2 or 3, or if DMA is active; otherwise returns the stored byte.
  - FEA0-FEFF: returns 8'h00.
  - FF46: returns the last written DMA value.
  - Any other address: no response (valid stays 0).
- CPU writes:
  - FE00-FE9F: dropped when ppu_mode_in is 2 or 3 or DMA is active; otherwise take effect at the next edge.
  - FEA0-FEFF: ignored.
  - cpu_rd_in and cpu_wr_in both high: the write takes priority and no read response is issued.
- DMA FSM:
  - IDLE -> START: on a CPU write to FF46 with value V. Latch src={V,8'h00}; clear the counters.
  - START -> XFER: after one tclk_in. dma_active_out rises on entering XFER.
  - XFER:
    - Every TICKS_PER_BYTE tclk_in pulses, assert dma_rd_out with dma_addr_out=src+i, held until dma_data_valid_in.
    - On data valid, write OAM[i]; i increments.
    - i==159 written -> IDLE; dma_active_out falls on the following clk.
  - A write to FF46 in START or XFER restarts the sequence: return to START with the new src and i=0.
  - An outstanding source read is abandoned; a late dma_data_valid_in is ignored.
  - DMA writes take priority over CPU writes in the same cycle, though CPU OAM writes are already blocked while DMA is active.
- Widths:
  - OAM index is 8 bits; byte counter 8 bits; tick counter $clog2(TICKS_PER_BYTE) bits, wrapping.
  - src+i has no carry beyond the low byte (i<160).
- Reset mid-DMA: aborts immediately; OAM keeps any bytes already written.

Decomposition:
- Shared package gb_pkg holds:
  - PPUState enum {HBlank, VBlank, OAMScan, Draw}.
  - Constants OAM_BASE, OAM_SIZE, DMA_REG.
  - DmaState enum {IDLE, START, XFER}.
- One sub-module, oam_dma_engine: DMA FSM, counters, source handshake. It outputs an OAM write index, data and enable.
- The top level holds the 160x8 array, the address decode and the blocking logic.

Test Plan:
- Mode 0: CPU writes FE05=8'h3C, then PPU reads FE05 -> ppu_data_out=8'h3C, valid exactly one clk later.
- Mode 2: CPU writes FE05=8'h77 -> dropped; CPU read FE05 returns 8'hFF; after mode 0, read FE05 returns 8'h3C.
- CPU writes FF46=8'hC1, source model returns (addr & 8'hFF) ^ 8'h5A:
  - dma_addr_out sweeps C100-C19F, one byte per 4 tclk_in.
  - Afterwards OAM[i]=i^8'h5A for all 160 bytes; dma_active_out low.
- During DMA: PPU read FE00 -> 8'hFF; CPU write FE10 ignored.
- Write FF46=8'hC2 at byte 50 -> restart at C200, i=0; final OAM matches the C2 source only.
- CPU read FEA0 -> 8'h00; PPU read FEA0 -> 8'hFF; rst_in asserted mid-DMA -> dma_active_out=0 next clk, FSM IDLE.
